// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared 512x8 data RAM.
// One core holds the bus per tenure; hog_flag marks long tenures.
module bus_arbiter #(
  parameter int N_CORES   = 2,
  parameter int HOG_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CORES-1:0]   grant_request,
  output logic [N_CORES-1:0]   grant_given,
  input  logic [N_CORES-1:0]   rw,
  input  logic [9*N_CORES-1:0] address,
  input  logic [8*N_CORES-1:0] data_out,
  output logic [7:0]           data_in,
  output logic [2:0]           owner,
  output logic                 hog_flag
);

  localparam int CW = $clog2(HOG_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    RELEASE
  } state_t;

  state_t state_q, state_d;

  logic [N_CORES-1:0] grant_q, grant_d;
  logic [2:0]         owner_q, owner_d;
  logic [2:0]         rr_q, rr_d;
  logic [CW-1:0]      ten_q, ten_d;

  logic [2:0]  pick;
  logic        found;
  logic [7:0]  onehot;
  logic [7:0]  req8;
  logic [7:0]  rw8;
  logic [71:0] addr72;
  logic [63:0] wd64;
  logic [8:0]  own_addr;
  logic [7:0]  own_wdata;
  logic        own_req;
  logic        own_rw;

  logic [7:0] mem [512];

  // widen per-core buses to 8 lanes so a 3-bit index always fits
  assign req8   = 8'(grant_request);
  assign rw8    = 8'(rw);
  assign addr72 = 72'(address);
  assign wd64   = 64'(data_out);

  assign own_req = req8[owner_q];
  assign own_rw  = rw8[owner_q];

  always_comb begin
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (owner_q == 3'(i)) begin
        own_addr  = addr72[i*9 +: 9];
        own_wdata = wd64[i*8 +: 8];
      end
    end
  end

  // scan upward from rr_ptr+1 with wrap; first requester wins
  always_comb begin
    logic [2:0] idx;
    idx   = rr_q;
    pick  = rr_q;
    found = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = (idx == 3'(N_CORES - 1)) ? 3'd0 : idx + 3'd1;
      if (!found && req8[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign onehot = 8'b1 << pick;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    ten_d   = ten_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANTED;
          grant_d = onehot[N_CORES-1:0];
          owner_d = pick;
          ten_d   = '0;
        end
      end
      GRANTED: begin
        if (ten_q != CW'(HOG_LIMIT)) begin
          ten_d = ten_q + CW'(1);
        end
        if (!own_req) begin
          state_d = RELEASE;
          grant_d = '0;
          rr_d    = owner_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= 3'(N_CORES - 1);
      ten_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      ten_q   <= ten_d;
    end
  end

  // RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (!reset && state_q == GRANTED && own_rw) begin
      mem[own_addr] <= own_wdata;
    end
  end

  assign data_in     = (state_q == GRANTED) ? mem[own_addr] : 8'h00;
  assign grant_given = grant_q;
  assign owner       = owner_q;
  assign hog_flag    = (ten_q == CW'(HOG_LIMIT));

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter
// against a tenure-level reference model.
module tb_bus_arbiter;

  localparam int N   = 2;
  localparam int HOG = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   rw = '0;
  logic [9*N-1:0] addr = '0;
  logic [8*N-1:0] wd = '0;
  logic [N-1:0]   grant_given;
  logic [7:0]     data_in;
  logic [2:0]     owner;
  logic           hog_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // model: 0 idle, 1 granted, 2 release
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_rr    = N - 1;
  int         m_ten   = 0;
  logic [7:0] m_mem [512];
  bit         m_known [512];

  always #5 clk = ~clk;

  bus_arbiter #(
    .N_CORES(N),
    .HOG_LIMIT(HOG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .grant_request(req),
    .grant_given(grant_given),
    .rw(rw),
    .address(addr),
    .data_out(wd),
    .data_in(data_in),
    .owner(owner),
    .hog_flag(hog_flag)
  );

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [8:0] a, input logic [7:0] d);
    req[c]        = r;
    rw[c]         = w;
    addr[c*9 +: 9] = a;
    wd[c*8 +: 8]   = d;
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_phase == 1) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [8:0] own_a();
    return addr[m_owner*9 +: 9];
  endfunction

  function automatic logic [7:0] exp_data();
    if (m_phase != 1) return 8'h00;
    return m_mem[own_a()];
  endfunction

  function automatic bit data_known();
    return (m_phase != 1) || m_known[own_a()];
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_rr    = N - 1;
    m_ten   = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_phase == 1) begin
      if (rw[m_owner]) begin
        m_mem[own_a()]   = wd[m_owner*8 +: 8];
        m_known[own_a()] = 1'b1;
      end
      if (m_ten < HOG) m_ten++;
      if (!req[m_owner]) begin
        m_rr    = m_owner;
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (|req) begin
      bit f;
      f = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (!f && req[c]) begin
          f       = 1'b1;
          m_owner = c;
        end
      end
      m_phase = 1;
      m_ten   = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++;
    if (grant_given !== '0) begin
      n_fail++;
      $display("FAIL reset_grant: got %b want 0", grant_given);
    end
    n_checks++;
    if (owner !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_owner: got %0d want 0", owner);
    end
    n_checks++;
    if (hog_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hog: got %b want 0", hog_flag);
    end
    n_checks++;
    if (data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 00", data_in);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_rw();
    set_core(0, 1'b1, 1'b0, 9'h000, 8'h00);
    step();
    n_checks++;
    if (grant_given !== 2'b01 || owner !== 3'd0) begin
      n_fail++;
      $display("FAIL rw_grant: got %b/%0d want 01/0", grant_given, owner);
    end
    set_core(0, 1'b1, 1'b1, 9'h000, 8'h55);
    step();
    set_core(0, 1'b1, 1'b1, 9'h1FF, 8'hAA);
    step();
    set_core(0, 1'b1, 1'b0, 9'h000, 8'h00);
    #1;
    n_checks++;
    if (data_in !== 8'h55) begin
      n_fail++;
      $display("FAIL rw_read0: got %h want 55", data_in);
    end
    step();
    set_core(0, 1'b1, 1'b0, 9'h1FF, 8'h00);
    #1;
    n_checks++;
    if (data_in !== 8'hAA) begin
      n_fail++;
      $display("FAIL rw_read1ff: got %h want aa", data_in);
    end
    n_checks++;
    if (grant_given !== 2'b01) begin
      n_fail++;
      $display("FAIL rw_held: got %b want 01", grant_given);
    end
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    step();
    n_checks++;
    if (grant_given !== '0 || data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL rw_release: got %b/%h want 00/00", grant_given, data_in);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    set_core(1, 1'b1, 1'b1, 9'h020, 8'h99);
    for (int t = 0; t < 10 && grant_given !== 2'b10; t++) step();
    n_checks++;
    if (grant_given !== 2'b10 || owner !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_pre_grant: got %b/%0d want 10/1", grant_given, owner);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (grant_given !== '0 || data_in !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_async: got %b/%h want 00/00", grant_given, data_in);
    end
    step();
    step();
    reset = 1'b0;
    set_core(1, 1'b1, 1'b0, 9'h020, 8'h00);
    step();
    n_checks++;
    if (grant_given !== 2'b10 || owner !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_regrant: got %b/%0d want 10/1", grant_given, owner);
    end
    set_core(1, 1'b0, 1'b0, 9'h000, 8'h00);
    step();
    step();
    step();
  endtask

  task automatic test_round_robin();
    int           order[$];
    int           first;
    int           run;
    int           gap;
    int           o;
    logic [N-1:0] prev;
    first = (m_rr + 1) % N;
    run   = 0;
    gap   = 0;
    o     = 0;
    prev  = '0;
    req   = '1;
    rw    = '0;
    for (int cyc = 0; cyc < 60 && order.size() < 4; cyc++) begin
      step();
      n_checks++;
      if (grant_given !== exp_grant()) begin
        n_fail++;
        $display("FAIL rr_grant: got %b want %b", grant_given, exp_grant());
      end
      if (grant_given != '0) begin
        for (int i = 0; i < N; i++) if (grant_given[i]) o = i;
        if (prev == '0) begin
          order.push_back(o);
          // dead cycles: RELEASE plus the IDLE evaluation cycle
          if (order.size() > 1) begin
            n_checks++;
            if (gap != 2) begin
              n_fail++;
              $display("FAIL rr_gap: got %0d want 2", gap);
            end
          end
          run = 0;
          gap = 0;
        end
        run++;
        req = '1;
        if (run == 3) req[o] = 1'b0;
      end else begin
        gap++;
        req = '1;
      end
      prev = grant_given;
    end
    n_checks++;
    if (order.size() != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d want 4", order.size());
    end
    foreach (order[i]) begin
      n_checks++;
      if (order[i] != (first + i) % N) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], (first + i) % N);
      end
    end
    req = '0;
    step();
    step();
    step();
  endtask

  task automatic test_isolation();
    set_core(0, 1'b1, 1'b1, 9'h010, 8'h77);
    for (int t = 0; t < 10 && grant_given !== 2'b01; t++) step();
    step();
    set_core(0, 1'b1, 1'b0, 9'h010, 8'h00);
    set_core(1, 1'b1, 1'b1, 9'h010, 8'h33);
    #1;
    n_checks++;
    if (data_in !== 8'h77) begin
      n_fail++;
      $display("FAIL iso_read: got %h want 77", data_in);
    end
    step();
    #1;
    n_checks++;
    if (data_in !== 8'h77 || grant_given !== 2'b01) begin
      n_fail++;
      $display("FAIL iso_hold: got %h/%b want 77/01", data_in, grant_given);
    end
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    set_core(1, 1'b1, 1'b0, 9'h010, 8'h00);
    for (int t = 0; t < 10 && grant_given !== 2'b10; t++) step();
    #1;
    n_checks++;
    if (grant_given !== 2'b10 || data_in !== 8'h77) begin
      n_fail++;
      $display("FAIL iso_mem: got %b/%h want 10/77", grant_given, data_in);
    end
    set_core(1, 1'b0, 1'b0, 9'h000, 8'h00);
    step();
    step();
    step();
  endtask

  task automatic test_hog();
    set_core(0, 1'b1, 1'b0, 9'h010, 8'h00);
    for (int t = 0; t < 10 && grant_given !== 2'b01; t++) step();
    for (int j = 1; j <= 70; j++) begin
      n_checks++;
      if (hog_flag !== (j > HOG) || grant_given !== 2'b01) begin
        n_fail++;
        $display("FAIL hog_cycle%0d: got %b/%b want %b/01",
                 j, hog_flag, grant_given, (j > HOG));
      end
      step();
    end
    set_core(0, 1'b0, 1'b0, 9'h010, 8'h00);
    step();
    step();
    set_core(0, 1'b1, 1'b0, 9'h010, 8'h00);
    step();
    n_checks++;
    if (grant_given !== 2'b01 || hog_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL hog_clear: got %b/%b want 01/0", grant_given, hog_flag);
    end
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    set_core(0, 1'b1, 1'b0, 9'h000, 8'h00);
    for (int t = 0; t < 10 && grant_given !== 2'b01; t++) step();
    step();
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    step();
    n_checks++;
    if (grant_given !== '0) begin
      n_fail++;
      $display("FAIL b2b_release: got %b want 00", grant_given);
    end
    set_core(0, 1'b1, 1'b0, 9'h000, 8'h00);
    step();
    n_checks++;
    if (grant_given !== '0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b want 00", grant_given);
    end
    step();
    n_checks++;
    if (grant_given !== 2'b01 || owner !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_regrant: got %b/%0d want 01/0", grant_given, owner);
    end
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    step();
    step();
    step();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++;
      if (grant_given !== exp_grant() || owner !== 3'(m_owner)) begin
        n_fail++;
        $display("FAIL rnd_grant@%0d: got %b/%0d want %b/%0d",
                 cyc, grant_given, owner, exp_grant(), m_owner);
      end
      n_checks++;
      if (hog_flag !== (m_ten == HOG)) begin
        n_fail++;
        $display("FAIL rnd_hog@%0d: got %b want %b", cyc, hog_flag, (m_ten == HOG));
      end
      if (data_known()) begin
        n_checks++;
        if (data_in !== exp_data()) begin
          n_fail++;
          $display("FAIL rnd_data@%0d: got %h want %h", cyc, data_in, exp_data());
        end
      end
      for (int c = 0; c < N; c++) begin
        logic r;
        r = req[c] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
        set_core(c, r, 1'($urandom_range(0, 1)),
                 9'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      step();
    end
    req = '0;
    step();
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_reset_mid();
    test_round_robin();
    test_isolation();
    test_hog();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
